// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and phase counts for the sequenced ALU
package alu_seq_pkg;

  localparam logic [7:0] OP_PUSH = 8'h55;
  localparam logic [7:0] OP_MOV  = 8'h89;
  localparam logic [7:0] OP_MOVI = 8'hb8;
  localparam logic [7:0] OP_POP  = 8'h5d;
  localparam logic [7:0] OP_RET  = 8'hc3;
  localparam logic [7:0] OP_CALL = 8'he2;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  typedef enum logic [2:0] {SEL_PASS, SEL_INC, SEL_DEC, SEL_IMM, SEL_CALL} sel_t;

  // Zero marks an unsupported opcode and sends the FSM down the error path.
  function automatic logic [1:0] num_phases(input logic [7:0] opcode);
    case (opcode)
      OP_PUSH, OP_POP, OP_RET: num_phases = 2'd2;
      OP_MOV, OP_MOVI:         num_phases = 2'd1;
      OP_CALL:                 num_phases = 2'd3;
      default:                 num_phases = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_datapath.sv
// rtl/alu_seq_datapath.sv - combinational per-phase result; flags built only with ALU_SEQ_FLAGS_EN
module alu_seq_datapath
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STACK_STEP = 1,
  parameter int CALL_LEN   = 5
) (
  input  logic [7:0]       opcode,
  input  logic [1:0]       phase,
  input  logic [WIDTH-1:0] operand,
  input  logic [23:0]      imm_field,
  input  logic [3:0]       num_of_ope,
  output logic [WIDTH-1:0] result
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  // With flags, one extra bit catches the carry/borrow of the final add/sub.
`ifdef ALU_SEQ_FLAGS_EN
  localparam int XW = WIDTH + 1;
`else
  localparam int XW = WIDTH;
`endif
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STACK_STEP);
  localparam logic [WIDTH-1:0] CALL_W = WIDTH'(CALL_LEN);

  sel_t             sel;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] rel_ext;
  logic [WIDTH-1:0] call_sum;
  logic [XW-1:0]    wide;

  always_comb begin
    sel = SEL_PASS;
    case (opcode)
      OP_PUSH: sel = (phase == 2'd0) ? SEL_INC : SEL_PASS;
      OP_MOVI: sel = SEL_IMM;
      OP_POP:  sel = (phase == 2'd0) ? SEL_PASS : SEL_DEC;
      OP_RET:  sel = SEL_DEC;
      OP_CALL: sel = (phase == 2'd0) ? SEL_INC : ((phase == 2'd1) ? SEL_PASS : SEL_CALL);
      default: sel = SEL_PASS;
    endcase
  end

  always_comb begin
    imm       = '0;
    imm[23:0] = {imm_field[7:0], imm_field[15:8], imm_field[23:16]};
    rel_ext   = {{(WIDTH-16){imm_field[7]}}, imm_field[7:0], imm_field[15:8]};
    call_sum  = operand + WIDTH'(num_of_ope) + rel_ext;
    case (sel)
      SEL_INC:  wide = XW'(operand) + XW'(STEP_W);
      SEL_DEC:  wide = XW'(operand) - XW'(STEP_W);
      SEL_IMM:  wide = XW'(imm);
      SEL_CALL: wide = XW'(call_sum) - XW'(CALL_W);
      default:  wide = XW'(operand);
    endcase
  end

  assign result = wide[WIDTH-1:0];

`ifdef ALU_SEQ_FLAGS_EN
  assign flags = {wide[WIDTH-1], wide[WIDTH], (wide[WIDTH-1:0] == '0)};
`endif

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - start/done sequenced ALU with per-phase operand handshake; ALU_SEQ_FLAGS_EN adds {SF,CF,ZF}
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STACK_STEP = 1,
  parameter int CALL_LEN   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      ope,
  input  logic [3:0]       num_of_ope,
  output logic             busy,
  output logic             reg_req,
  output logic [1:0]       phase,
  input  logic             reg_valid,
  input  logic [WIDTH-1:0] registor_in,
  output logic [WIDTH-1:0] alu_result_bus,
  output logic             result_valid,
  output logic             done,
  output logic             err
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  state_t           state;
  logic [31:0]      ope_q;
  logic [3:0]       num_q;
  logic [1:0]       last_phase;
  logic [WIDTH-1:0] dp_result;
`ifdef ALU_SEQ_FLAGS_EN
  logic [2:0]       dp_flags;
`endif

  assign last_phase = num_phases(ope_q[31:24]) - 2'd1;

  alu_seq_datapath #(
    .WIDTH      (WIDTH),
    .STACK_STEP (STACK_STEP),
    .CALL_LEN   (CALL_LEN)
  ) u_datapath (
    .opcode     (ope_q[31:24]),
    .phase      (phase),
    .operand    (registor_in),
    .imm_field  (ope_q[23:0]),
    .num_of_ope (num_q),
    .result     (dp_result)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flags      (dp_flags)
`endif
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      reg_req        <= 1'b0;
      phase          <= 2'd0;
      alu_result_bus <= '0;
      result_valid   <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      ope_q          <= '0;
      num_q          <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      flags          <= 3'b000;
`endif
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE so operations can run back to back.
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            ope_q <= ope;
            num_q <= num_of_ope;
            phase <= 2'd0;
            if (num_phases(ope[31:24]) != 2'd0) begin
              state   <= REQ;
              busy    <= 1'b1;
              reg_req <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (reg_valid) begin
            alu_result_bus <= dp_result;
            result_valid   <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            flags          <= dp_flags;
`endif
            if (phase == last_phase) begin
              state   <= DONE;
              busy    <= 1'b0;
              reg_req <= 1'b0;
              done    <= 1'b1;
            end else begin
              phase <= phase + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized bench for alu_seq against a plain-arithmetic reference; honours ALU_SEQ_FLAGS_EN
module tb_alu_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] ope;
  logic [3:0]  num_of_ope;
  logic        busy;
  logic        reg_req;
  logic [1:0]  phase;
  logic        reg_valid;
  logic [31:0] registor_in;
  logic [31:0] alu_result_bus;
  logic        result_valid;
  logic        done;
  logic        err;
`ifdef ALU_SEQ_FLAGS_EN
  logic [2:0]  flags;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  alu_seq dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .ope            (ope),
    .num_of_ope     (num_of_ope),
    .busy           (busy),
    .reg_req        (reg_req),
    .phase          (phase),
    .reg_valid      (reg_valid),
    .registor_in    (registor_in),
    .alu_result_bus (alu_result_bus),
    .result_valid   (result_valid),
    .done           (done),
    .err            (err)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flags          (flags)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int ref_phases(input logic [7:0] op);
    case (op)
      8'h55, 8'h5d, 8'hc3: return 2;
      8'h89, 8'hb8:        return 1;
      8'he2:               return 3;
      default:             return 0;
    endcase
  endfunction

  // Expected result of phase ph with STACK_STEP=1, CALL_LEN=5, 32-bit wrap.
  function automatic logic [31:0] ref_result(input int ph, input logic [31:0] o, input logic [3:0] n,
                                             input logic [31:0] r, output logic [2:0] fl);
    longint unsigned rr, v, s;
    longint          relv;
    logic [15:0]     rel16;
    logic [31:0]     res;
    bit              cf;
    rr = r;
    cf = 0;
    v  = rr;
    rel16 = {o[7:0], o[15:8]};
    relv  = longint'($signed(rel16));
    case (o[31:24])
      8'h55: if (ph == 0) begin v = rr + 1; cf = (v >= 64'h1_0000_0000); end
      8'hb8: v = {o[7:0], o[15:8], o[23:16]};
      8'h5d: if (ph == 1) begin v = rr - 1; cf = (rr < 1); end
      8'hc3: begin v = rr - 1; cf = (rr < 1); end
      8'he2: begin
        if (ph == 0) begin v = rr + 1; cf = (v >= 64'h1_0000_0000); end
        else if (ph == 2) begin
          s  = (rr + longint'(n) + relv) & 64'hffff_ffff;
          v  = s - 5;
          cf = (s < 5);
        end
      end
      default: v = rr;
    endcase
    res = v[31:0];
    fl  = {res[31], cf, res == 32'd0};
    return res;
  endfunction

  // Runs one operation from the start cycle through its done cycle; returns in the done cycle.
  task automatic run_op(input logic [31:0] o, input logic [3:0] n, input logic [31:0] r [3], input bit fast);
    int np;
    int d;
    logic [31:0] exp;
    logic [2:0]  ef;
    np = ref_phases(o[31:24]);
    start = 1'b1;
    ope = o;
    num_of_ope = n;
    step();
    start = 1'b0;
    ope = $urandom;
    num_of_ope = 4'($urandom);
    if (np == 0) begin
      check("err_done", done, 1);
      check("err_flag", err, 1);
      check("err_req", reg_req, 0);
      check("err_rvalid", result_valid, 0);
      check("err_busy", busy, 0);
      return;
    end
    for (int ph = 0; ph < np; ph++) begin
      d = fast ? 0 : $urandom_range(0, 2);
      check("req", reg_req, 1);
      check("phase", phase, ph);
      check("busy", busy, 1);
      for (int k = 0; k < d; k++) begin
        start = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        check("req_hold", reg_req, 1);
        check("rvalid_idle", result_valid, 0);
        check("done_idle", done, 0);
      end
      reg_valid = 1'b1;
      registor_in = r[ph];
      step();
      reg_valid = 1'b0;
      registor_in = $urandom;
      exp = ref_result(ph, o, n, r[ph], ef);
      check("result", alu_result_bus, exp);
      check("rvalid", result_valid, 1);
      check("done", done, (ph == np - 1));
      check("err", err, 0);
`ifdef ALU_SEQ_FLAGS_EN
      check("flags", flags, ef);
`endif
    end
    check("busy_done", busy, 0);
  endtask

  task automatic idle_check();
    step();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_rvalid", result_valid, 0);
  endtask

  logic [31:0] rv [3];
  logic [7:0]  ops [7];
  logic [31:0] hold;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ope = '0;
    num_of_ope = '0;
    reg_valid = 1'b0;
    registor_in = '0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_req", reg_req, 0);
    check("rst_phase", phase, 0);
    check("rst_result", alu_result_bus, 0);
    check("rst_rvalid", result_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    step();

    // Directed cases from the reference scenarios.
    rv = '{32'h1234, 32'h0, 32'h0};
    run_op(32'hb8_34_56_78, 4'd5, rv, 1'b1);
    check("movi_imm", alu_result_bus, 32'h0078_5634);
    idle_check();
    rv = '{32'h100, 32'h200, 32'h0};
    run_op(32'h55_00_00_00, 4'd1, rv, 1'b0);
    check("push_last", alu_result_bus, 32'h200);
    idle_check();
    rv = '{32'h10, 32'h30, 32'h40};
    run_op(32'he2_00_ee_ff, 4'd5, rv, 1'b0);
    check("call_target", alu_result_bus, 32'h2e);
    rv = '{32'h77, 32'h0, 32'h0};
    run_op(32'h5d_00_00_00, 4'd1, rv, 1'b1);
    check("pop_wrap", alu_result_bus, 32'hffff_ffff);
    run_op(32'h90_00_00_00, 4'd1, rv, 1'b1);
    idle_check();

    // Reset in push phase 1 with no operand pending.
    start = 1'b1;
    ope = 32'h55_00_00_00;
    step();
    start = 1'b0;
    reg_valid = 1'b1;
    registor_in = 32'h500;
    step();
    reg_valid = 1'b0;
    check("pre_rst_phase", phase, 1);
    step();
    reset = 1'b1;
    step();
    check("abort_busy", busy, 0);
    check("abort_req", reg_req, 0);
    check("abort_phase", phase, 0);
    check("abort_result", alu_result_bus, 0);
    check("abort_rvalid", result_valid, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    reset = 1'b0;
    idle_check();
    rv = '{32'h40, 32'h0, 32'h0};
    run_op(32'hc3_00_00_00, 4'd1, rv, 1'b0);

    // Randomized operations, some back to back from the done cycle.
    ops = '{8'h55, 8'h89, 8'hb8, 8'h5d, 8'hc3, 8'he2, 8'h00};
    for (int i = 0; i < 80; i++) begin
      logic [7:0] op;
      op = ops[$urandom_range(0, 6)];
      if (op == 8'h00) op = 8'($urandom);
      for (int j = 0; j < 3; j++) begin
        case ($urandom_range(0, 3))
          0:       hold = 32'h0;
          1:       hold = 32'hffff_ffff;
          default: hold = $urandom;
        endcase
        rv[j] = hold;
      end
      hold = $urandom;
      run_op({op, hold[23:0]}, 4'($urandom), rv, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
